// File: rtl/cflog_writer.sv
// ---------------------------------------------------------------------------
// cflog_writer
//
// Control-flow log writer. Each control-flow transfer reported on br_valid is
// captured and written into a LOG region of memory as one or two 16-bit words.
// When the region fills up, the block raises flush_req and waits for the TCB
// to consume the log (flush_done) before it accepts new transfers. Transfers
// that arrive while the block is busy or full are dropped and recorded in the
// sticky overflow flag.
//
// Build option:
//   CFLOG_SRC_EN  defined   -> each transfer writes src then dst (two words)
//                 undefined -> each transfer writes dst only (one word)
//
// Parameters:
//   LOG_MIN   byte base address of the LOG region
//   LOG_SIZE  LOG capacity in 2-byte words (even value)
//
// Ports:
//   clk         in   system clock, rising-edge
//   reset_n     in   synchronous active-low reset
//   br_valid    in   one-cycle pulse marking a control-flow transfer
//   br_src      in   [15:0] source PC of the transfer
//   br_dst      in   [15:0] destination PC of the transfer
//   log_wr      out  write request to LOG memory
//   log_addr    out  [15:0] byte address of the current write
//   log_data    out  [15:0] word to write
//   log_ack     in   memory accepts the write this cycle
//   log_ptr     out  [15:0] words written since last flush
//   flush_req   out  LOG full, request attestation/flush
//   flush_done  in   TCB finished consuming LOG
//   overflow    out  sticky: at least one transfer dropped
// ---------------------------------------------------------------------------
module cflog_writer #(
  parameter logic [15:0] LOG_MIN  = 16'h01b0,
  parameter logic [15:0] LOG_SIZE = 16'h0080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        br_valid,
  input  logic [15:0] br_src,
  input  logic [15:0] br_dst,
  output logic        log_wr,
  output logic [15:0] log_addr,
  output logic [15:0] log_data,
  input  logic        log_ack,
  output logic [15:0] log_ptr,
  output logic        flush_req,
  input  logic        flush_done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_SRC = 2'd1,
    WR_DST = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_ptr;
  logic [15:0] w_nextPtr;
  logic [15:0] w_ptrInc;
  logic        r_overflow;
  logic        w_nextOverflow;
  logic        w_capture;

  // Next-state logic. A transfer is only accepted in IDLE; anything arriving
  // while a write is in flight or while the log is full is dropped and marks
  // overflow. In FULL a flush clears the flag, and the clear takes priority
  // over a transfer dropped in the same cycle. Because LOG_SIZE is even and
  // two-word transfers always start on an even pointer, the full check only
  // needs to happen after the dst word.
  always_comb begin
    w_nextState    = r_state;
    w_nextPtr      = r_ptr;
    w_nextOverflow = r_overflow;
    w_capture      = 1'b0;
    w_ptrInc       = r_ptr + 16'd1;
    case (r_state)
      IDLE: begin
        if (br_valid) begin
          w_capture = 1'b1;
`ifdef CFLOG_SRC_EN
          w_nextState = WR_SRC;
`else
          w_nextState = WR_DST;
`endif
        end
      end
      WR_SRC: begin
        if (br_valid) begin
          w_nextOverflow = 1'b1;
        end
        if (log_ack) begin
          w_nextPtr   = w_ptrInc;
          w_nextState = WR_DST;
        end
      end
      WR_DST: begin
        if (br_valid) begin
          w_nextOverflow = 1'b1;
        end
        if (log_ack) begin
          w_nextPtr   = w_ptrInc;
          w_nextState = (w_ptrInc == LOG_SIZE) ? FULL : IDLE;
        end
      end
      FULL: begin
        if (flush_done) begin
          w_nextPtr      = 16'd0;
          w_nextOverflow = 1'b0;
          w_nextState    = IDLE;
        end else if (br_valid) begin
          w_nextOverflow = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any write in flight: the
  // state returns to IDLE, so log_wr drops on the very next cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= 16'd0;
      r_overflow <= 1'b0;
      r_src      <= 16'd0;
      r_dst      <= 16'd0;
    end else begin
      r_state    <= w_nextState;
      r_ptr      <= w_nextPtr;
      r_overflow <= w_nextOverflow;
      if (w_capture) begin
        r_src <= br_src;
        r_dst <= br_dst;
      end
    end
  end

  // Outputs are decoded straight from registered state, so the write request
  // appears the cycle after capture and stays stable until acknowledged.
  // The address is the word pointer scaled to bytes, wrapping at 16 bits.
  assign log_wr    = (r_state == WR_SRC) || (r_state == WR_DST);
  assign log_addr  = LOG_MIN + {r_ptr[14:0], 1'b0};
  assign log_data  = (r_state == WR_SRC) ? r_src :
                     (r_state == WR_DST) ? r_dst : 16'd0;
  assign log_ptr   = r_ptr;
  assign flush_req = (r_state == FULL);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_cflog_writer.sv
// ---------------------------------------------------------------------------
// tb_cflog_writer
//
// Scoreboard bench for cflog_writer. The driver applies one cycle of inputs
// at a time and advances a transaction-level model of the log (word pointer,
// words still owed for the current transfer, full and overflow flags). Every
// accepted transfer pushes the memory words it must produce into writeQ, and
// every edge pushes the expected status into statusQ. Two monitor processes
// pop and compare independently of the driver.
// ---------------------------------------------------------------------------
module tb_cflog_writer;

  localparam logic [15:0] LOG_MIN  = 16'h01b0;
  localparam logic [15:0] LOG_SIZE = 16'h0080;
`ifdef CFLOG_SRC_EN
  localparam int WORDS_PER_XFER = 2;
`else
  localparam int WORDS_PER_XFER = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        br_valid;
  logic [15:0] br_src;
  logic [15:0] br_dst;
  logic        log_wr;
  logic [15:0] log_addr;
  logic [15:0] log_data;
  logic        log_ack;
  logic [15:0] log_ptr;
  logic        flush_req;
  logic        flush_done;
  logic        overflow;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } write_t;

  typedef struct {
    logic        wr;
    logic [15:0] ptr;
    logic        flushReq;
    logic        overflow;
  } status_t;

  write_t  writeQ[$];
  status_t statusQ[$];

  int checks = 0;
  int errors = 0;

  int mPtr      = 0;
  int mPending  = 0;
  bit mOverflow = 1'b0;
  bit mFull     = 1'b0;

  // Clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  cflog_writer #(
    .LOG_MIN (LOG_MIN),
    .LOG_SIZE(LOG_SIZE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .br_valid  (br_valid),
    .br_src    (br_src),
    .br_dst    (br_dst),
    .log_wr    (log_wr),
    .log_addr  (log_addr),
    .log_data  (log_data),
    .log_ack   (log_ack),
    .log_ptr   (log_ptr),
    .flush_req (flush_req),
    .flush_done(flush_done),
    .overflow  (overflow)
  );

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Log behaviour at one rising edge, expressed as word bookkeeping: an idle
  // log accepts a transfer and owes WORDS_PER_XFER words; each acknowledged
  // cycle pays one word; the log is full once the last owed word lands on
  // capacity; a flush empties it and forgives overflow.
  task automatic modelEdge(input logic rstn, input logic bv,
                           input logic [15:0] src, input logic [15:0] dst,
                           input logic ack, input logic fd);
    status_t s;
    write_t  w;
    if (!rstn) begin
      mPtr      = 0;
      mPending  = 0;
      mOverflow = 1'b0;
      mFull     = 1'b0;
      writeQ.delete();
    end else if (mFull) begin
      if (fd) begin
        mPtr      = 0;
        mOverflow = 1'b0;
        mFull     = 1'b0;
      end else if (bv) begin
        mOverflow = 1'b1;
      end
    end else if (mPending > 0) begin
      if (bv) mOverflow = 1'b1;
      if (ack) begin
        mPtr++;
        mPending--;
        if (mPending == 0 && mPtr == int'(LOG_SIZE)) mFull = 1'b1;
      end
    end else if (bv) begin
      mPending = WORDS_PER_XFER;
      for (int k = 0; k < WORDS_PER_XFER; k++) begin
        w.addr = LOG_MIN + 16'(2 * (mPtr + k));
        w.data = (WORDS_PER_XFER == 2 && k == 0) ? src : dst;
        writeQ.push_back(w);
      end
    end
    s.wr       = (mPending > 0);
    s.ptr      = 16'(mPtr);
    s.flushReq = mFull;
    s.overflow = mOverflow;
    statusQ.push_back(s);
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, and
  // return 2 time units after the edge so the next drive is clear of it.
  task automatic applyStimulus(input logic rstn, input logic bv,
                               input logic [15:0] src, input logic [15:0] dst,
                               input logic ack, input logic fd);
    reset_n    = rstn;
    br_valid   = bv;
    br_src     = src;
    br_dst     = dst;
    log_ack    = ack;
    flush_done = fd;
    @(posedge clk);
    modelEdge(rstn, bv, src, dst, ack, fd);
    #2;
  endtask

  // Status monitor: one expected snapshot per edge, compared 1 unit after it.
  always @(posedge clk) begin
    status_t s;
    #1;
    if (statusQ.size() > 0) begin
      s = statusQ.pop_front();
      checkOutput("log_wr", {31'd0, log_wr}, {31'd0, s.wr});
      checkOutput("log_ptr", {16'd0, log_ptr}, {16'd0, s.ptr});
      checkOutput("flush_req", {31'd0, flush_req}, {31'd0, s.flushReq});
      checkOutput("overflow", {31'd0, overflow}, {31'd0, s.overflow});
    end
  end

  // Write monitor: whenever the DUT presents a write, it must match the
  // oldest owed word; the word is retired when the memory acknowledges it.
  always @(negedge clk) begin
    if (log_wr === 1'b1) begin
      if (writeQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                 log_addr, log_data);
      end else begin
        checkOutput("log_addr", {16'd0, log_addr}, {16'd0, writeQ[0].addr});
        checkOutput("log_data", {16'd0, log_data}, {16'd0, writeQ[0].data});
        if (log_ack && reset_n) void'(writeQ.pop_front());
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    br_valid   = 1'b0;
    br_src     = 16'd0;
    br_dst     = 16'd0;
    log_ack    = 1'b0;
    flush_done = 1'b0;

    // Reset values
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("reset_addr", {16'd0, log_addr}, {16'd0, LOG_MIN});
    checkOutput("reset_data", {16'd0, log_data}, 32'd0);
    checkOutput("reset_wr", {31'd0, log_wr}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Basic transfer with ack tied high
    applyStimulus(1'b1, 1'b1, 16'hE010, 16'hE200, 1'b1, 1'b0);
    checkOutput("first_wr_latency", {31'd0, log_wr}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    checkOutput("basic_ptr", {16'd0, log_ptr}, WORDS_PER_XFER);

    // Stalled write: three cycles without ack, then drain
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("stall_ptr", {16'd0, log_ptr}, WORDS_PER_XFER);
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Transfer arriving while a write is in flight is dropped
    applyStimulus(1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    checkOutput("busy_overflow", {31'd0, overflow}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Fill the log to capacity
    for (int n = 0; n < 300 && !mFull; n++) begin
      applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      while (mPending > 0) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    checkOutput("full_ptr", {16'd0, log_ptr}, {16'd0, LOG_SIZE});
    checkOutput("full_flush_req", {31'd0, flush_req}, 32'd1);

    // Transfers while full are dropped without a write
    applyStimulus(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
    checkOutput("full_drop_wr", {31'd0, log_wr}, 32'd0);
    checkOutput("full_drop_overflow", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Refill, then flush with a coincident transfer: clear wins
    for (int n = 0; n < 300 && !mFull; n++) begin
      applyStimulus(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      while (mPending > 0) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1);
    checkOutput("flush_ptr", {16'd0, log_ptr}, 32'd0);
    checkOutput("flush_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("flush_req_clear", {31'd0, flush_req}, 32'd0);

    // First transfer after flush starts at the base address
    applyStimulus(1'b1, 1'b1, 16'h7777, 16'h8888, 1'b0, 1'b0);
    checkOutput("post_flush_addr", {16'd0, log_addr}, {16'd0, LOG_MIN});
    if (WORDS_PER_XFER == 2) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Reset while the dst word is pending and unacknowledged
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("reset_mid_wr", {31'd0, log_wr}, 32'd0);
    checkOutput("reset_mid_ptr", {16'd0, log_ptr}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Randomized traffic with sporadic resets and flushes
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 499) != 0,
                    $urandom_range(0, 9) < 3,
                    16'($urandom), 16'($urandom),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 19) == 0);
    end

    // Drain outstanding words and confirm every owed write appeared
    repeat (4) applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    checkOutput("writes_drained", writeQ.size(), 32'd0);

    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cflog_writer.md
CFLOG_WRITER -- requirements
Module: cflog_writer

Interface
REQ-001 SHALL have parameter LOG_MIN, default 16'h01b0, byte base address of the LOG region.
REQ-002 SHALL have parameter LOG_SIZE, default 16'h0080, LOG capacity in 2-byte words (even value).
REQ-003 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port br_valid  input  1  one-cycle pulse marking a control-flow transfer.
REQ-006 SHALL have port br_src  input  16  source PC of the transfer.
REQ-007 SHALL have port br_dst  input  16  destination PC of the transfer.
REQ-008 SHALL have port log_wr  output  1  write request to LOG memory.
REQ-009 SHALL have port log_addr  output  16  byte address of the current write.
REQ-010 SHALL have port log_data  output  16  word to write.
REQ-011 SHALL have port log_ack  input  1  memory accepts the write this cycle.
REQ-012 SHALL have port log_ptr  output  16  number of words written since last flush.
REQ-013 SHALL have port flush_req  output  1  LOG full, request TCB attestation/flush.
REQ-014 SHALL have port flush_done  input  1  TCB finished consuming LOG.
REQ-015 SHALL have port overflow  output  1  sticky: at least one transfer dropped.

Function
REQ-016 SHALL implement states IDLE, WR_SRC, WR_DST, FULL.
REQ-017 IDLE + br_valid SHALL capture br_src/br_dst into internal registers and move to WR_SRC (src logging on) or WR_DST (off).
REQ-018 log_wr SHALL assert the cycle after capture; latency br_valid to first log_wr = 1 cycle.
REQ-019 In WR_SRC/WR_DST log_wr SHALL be 1 and log_addr = LOG_MIN + 2*log_ptr (mod 2^16), log_data = captured src or dst, all stable until log_ack.
REQ-020 On log_ack, log_ptr SHALL increment by 1 that edge; WR_SRC -> WR_DST; WR_DST -> FULL if new log_ptr == LOG_SIZE, else IDLE.
REQ-021 log_wr SHALL be 0 in IDLE and FULL.
REQ-022 br_valid in any state other than IDLE SHALL be dropped and SHALL set overflow the next edge.
REQ-023 FULL SHALL hold flush_req = 1; flush_done in FULL SHALL clear log_ptr, overflow and flush_req and return to IDLE next edge.
REQ-024 flush_done outside FULL SHALL be ignored.
REQ-025 br_valid coinciding with flush_done in FULL SHALL be dropped and overflow SHALL end cleared (clear wins).
REQ-026 br_valid coinciding with log_ack of the final word SHALL be dropped and set overflow.
REQ-027 log_ptr SHALL never exceed LOG_SIZE.

Reset
REQ-028 reset_n low at a rising edge SHALL force IDLE, log_ptr = 0, log_wr = 0, log_addr = LOG_MIN, log_data = 0, flush_req = 0, overflow = 0, captured registers = 0.
REQ-029 Reset mid-write SHALL abandon the pending write without a further log_wr cycle.

Configuration
REQ-030 With CFLOG_SRC_EN defined, each transfer SHALL write two words (src at log_ptr, dst at log_ptr+1) via WR_SRC then WR_DST.
REQ-031 Without CFLOG_SRC_EN, WR_SRC SHALL be unreachable and each transfer SHALL write only dst (one word).

Verification
REQ-032 SRC_EN, reset, br_valid src=16'hE010 dst=16'hE200, log_ack tied 1 -> writes (01b0,E010),(01b2,E200); log_ptr=2; IDLE.
REQ-033 log_ack held 0 for 3 cycles in WR_SRC -> log_wr, log_addr, log_data unchanged for those cycles; log_ptr unchanged until ack.
REQ-034 64 transfers with SRC_EN, ack=1 -> last write at 16'h02ae, log_ptr=16'h0080, flush_req=1; further br_valid -> overflow=1, no log_wr.
REQ-035 In FULL pulse flush_done -> next cycle log_ptr=0, flush_req=0, overflow=0; next transfer writes at 16'h01b0.
REQ-036 br_valid during WR_DST -> dropped, overflow=1, exactly two words written.
REQ-037 reset_n low during WR_DST with log_ack=0 -> next cycle log_wr=0, log_ptr=0, state IDLE.
